// File: rtl/mmc_defs_pkg.sv
// Shared MMC host definitions: response types, CRC7 polynomial and command FSM state encoding.
// Pure declarations; no logic, no latency, no flow control.
package mmc_defs_pkg;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_48   = 2'd1;
  localparam logic [1:0] RESP_136  = 2'd2;

  // x^7 + x^3 + 1, implicit x^7 term dropped
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_WAIT_CMD = 3'd2,
    ST_ARM      = 3'd3,
    ST_RESP     = 3'd4,
    ST_CHECK    = 3'd5,
    ST_DONE     = 3'd6
  } cmd_state_t;

endpackage

// File: rtl/mmc_cmd_ctrl_if.sv
// Command-line PHY bus between the command sequencer and the serialiser/deserialiser pair.
// Pulse-based handshakes only; the PHY side has no backpressure beyond its done/complete pulses.
interface mmc_cmd_ctrl_if;
  logic         ser_start_o;
  logic [47:0]  ser_frame_o;
  logic         ser_done_i;
  logic         des_start_o;
  logic         des_abort_o;
  logic         des_r2_mode_o;
  logic [135:0] des_resp_i;
  logic         des_complete_i;

  modport master (
    output ser_start_o, ser_frame_o, des_start_o, des_abort_o, des_r2_mode_o,
    input  ser_done_i, des_resp_i, des_complete_i
  );

  modport slave (
    input  ser_start_o, ser_frame_o, des_start_o, des_abort_o, des_r2_mode_o,
    output ser_done_i, des_resp_i, des_complete_i
  );
endinterface

// File: rtl/mmc_crc7.sv
// Combinational CRC7 (x^7+x^3+1, init 0) over a W-bit vector, MSB first.
// Zero latency, no flow control.
module mmc_crc7
  import mmc_defs_pkg::*;
#(
  parameter int W = 40
) (
  input  logic [W-1:0] data,
  output logic [6:0]   crc
);

  logic fb;

  always_comb begin
    crc = '0;
    fb  = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/mmc_cmd_ctrl.sv
// MMC command-phase sequencer: frame build + CRC7, serialiser start, response arm/timeout/CRC check.
// Start to ser_start is 1 cycle; requests are ignored while busy; abort returns to IDLE next cycle.
module mmc_cmd_ctrl
  import mmc_defs_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           bitclk_i,
  input  logic           cmd_start_i,
  input  logic [5:0]     cmd_index_i,
  input  logic [31:0]    cmd_arg_i,
  input  logic [1:0]     resp_type_i,
  input  logic           crc_en_i,
  input  logic           abort_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_timeout_o,
  output logic           err_crc_o,
  output logic [135:0]   resp_o,
  mmc_cmd_ctrl_if.master phy
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  cmd_state_t   state_q, state_d;
  logic [47:0]  frame_q;
  logic [1:0]   type_q;
  logic         crc_en_q;
  logic [135:0] resp_q;
  logic [7:0]   cnt_q;
  logic         bitclk_q;
  logic         err_to_q, err_crc_q;

  logic         accept;
  logic         rise;
  logic         to_hit;
  logic         set_to, set_crc;
  logic         des_abort;
  logic [6:0]   frame_crc;
  logic [6:0]   resp_crc;
  logic [1:0]   type_in;

  mmc_crc7 #(.W(40)) u_crc_frame (
    .data ({2'b01, cmd_index_i, cmd_arg_i}),
    .crc  (frame_crc)
  );

  mmc_crc7 #(.W(39)) u_crc_resp (
    .data (resp_q[46:8]),
    .crc  (resp_crc)
  );

  assign accept  = (state_q == ST_IDLE) && cmd_start_i;
  assign rise    = bitclk_i & ~bitclk_q;
  assign to_hit  = rise && (cnt_q == TO_LAST);
  // Reserved type 3 behaves exactly like "no response"
  assign type_in = (resp_type_i == 2'd3) ? RESP_NONE : resp_type_i;

  always_comb begin
    state_d   = state_q;
    set_to    = 1'b0;
    set_crc   = 1'b0;
    des_abort = 1'b0;
    case (state_q)
      ST_IDLE:     if (cmd_start_i) state_d = ST_CMD;
      ST_CMD:      state_d = ST_WAIT_CMD;
      ST_WAIT_CMD: if (phy.ser_done_i) state_d = (type_q == RESP_NONE) ? ST_DONE : ST_ARM;
      ST_ARM:      state_d = ST_RESP;
      ST_RESP: begin
        if (phy.des_complete_i) begin
          state_d = ST_CHECK;
        end else if (to_hit) begin
          state_d   = ST_DONE;
          set_to    = 1'b1;
          des_abort = 1'b1;
        end
      end
      ST_CHECK: begin
        state_d = ST_DONE;
        set_crc = (type_q == RESP_48) && crc_en_q && (resp_crc != resp_q[7:1]);
      end
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // Abort overrides every transition and leaves the error flags untouched
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      set_to    = 1'b0;
      set_crc   = 1'b0;
      des_abort = (state_q == ST_ARM) || (state_q == ST_RESP);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      type_q    <= RESP_NONE;
      crc_en_q  <= 1'b0;
      resp_q    <= '0;
      cnt_q     <= '0;
      bitclk_q  <= 1'b0;
      err_to_q  <= 1'b0;
      err_crc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitclk_q <= bitclk_i;
      if (accept) begin
        frame_q   <= {2'b01, cmd_index_i, cmd_arg_i, frame_crc, 1'b1};
        type_q    <= type_in;
        crc_en_q  <= crc_en_i;
        err_to_q  <= 1'b0;
        err_crc_q <= 1'b0;
      end else begin
        if (set_to)  err_to_q  <= 1'b1;
        if (set_crc) err_crc_q <= 1'b1;
      end
      if (state_q == ST_ARM) begin
        cnt_q <= '0;
      end else if ((state_q == ST_RESP) && rise && (cnt_q != 8'hFF)) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if ((state_q == ST_RESP) && phy.des_complete_i && !abort_i) begin
        resp_q <= phy.des_resp_i;
      end
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);
  assign err_timeout_o = err_to_q;
  assign err_crc_o     = err_crc_q;
  assign resp_o        = resp_q;

  assign phy.ser_start_o   = (state_q == ST_CMD);
  assign phy.ser_frame_o   = frame_q;
  assign phy.des_start_o   = (state_q == ST_ARM);
  // No abort pulse towards a deserialiser that is being reset alongside us
  assign phy.des_abort_o   = des_abort && !rst_i;
  assign phy.des_r2_mode_o = ((state_q == ST_ARM) || (state_q == ST_RESP)) && (type_q == RESP_136);

endmodule

// File: tb/tb_mmc_cmd_ctrl.sv
// Directed bench for mmc_cmd_ctrl; expected frames and completion status are queued at issue time
// and checked by a monitor whenever ser_start_o or done_o is presented.
module tb_mmc_cmd_ctrl;
  import mmc_defs_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         bitclk_i;
  logic         cmd_start_i;
  logic [5:0]   cmd_index_i;
  logic [31:0]  cmd_arg_i;
  logic [1:0]   resp_type_i;
  logic         crc_en_i;
  logic         abort_i;
  logic         busy_o, done_o, err_timeout_o, err_crc_o;
  logic [135:0] resp_o;

  mmc_cmd_ctrl_if phy ();

  mmc_cmd_ctrl #(.TIMEOUT(16)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .bitclk_i      (bitclk_i),
    .cmd_start_i   (cmd_start_i),
    .cmd_index_i   (cmd_index_i),
    .cmd_arg_i     (cmd_arg_i),
    .resp_type_i   (resp_type_i),
    .crc_en_i      (crc_en_i),
    .abort_i       (abort_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_timeout_o (err_timeout_o),
    .err_crc_o     (err_crc_o),
    .resp_o        (resp_o),
    .phy           (phy)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         to;
    logic         crc;
    logic [135:0] resp;
  } exp_t;

  exp_t         exp_q[$];
  logic [47:0]  frame_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_ser   = 0;
  logic [135:0] resp_good, resp_bad, resp_r2;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_done(input logic to, input logic crc, input logic [135:0] resp);
    exp_t e;
    e.to   = to;
    e.crc  = crc;
    e.resp = resp;
    exp_q.push_back(e);
  endtask

  // Leaves the DUT in CMD with the request pulse removed
  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                           input logic ce, input logic [47:0] exp_frame);
    cmd_index_i = idx;
    cmd_arg_i   = arg;
    resp_type_i = typ;
    crc_en_i    = ce;
    cmd_start_i = 1'b1;
    frame_q.push_back(exp_frame);
    tick();
    cmd_start_i = 1'b0;
    check("ser_start_at_n1", {135'b0, phy.ser_start_o}, 136'd1);
    check("busy_at_n1", {135'b0, busy_o}, 136'd1);
  endtask

  // From CMD: serialiser completes, DUT lands in ARM (or DONE for no-response)
  task automatic finish_ser();
    tick();
    phy.ser_done_i = 1'b1;
    tick();
    phy.ser_done_i = 1'b0;
  endtask

  // From ARM: deliver a response, walk CHECK and DONE back to IDLE
  task automatic run_resp(input logic [135:0] resp, input logic r2);
    check("des_start_arm", {135'b0, phy.des_start_o}, 136'd1);
    check("r2_mode_arm", {135'b0, phy.des_r2_mode_o}, {135'b0, r2});
    tick();
    check("r2_mode_resp", {135'b0, phy.des_r2_mode_o}, {135'b0, r2});
    tick();
    phy.des_resp_i     = resp;
    phy.des_complete_i = 1'b1;
    tick();
    phy.des_complete_i = 1'b0;
    check("resp_at_check", resp_o, resp);
    tick();
    check("done_at_k2", {135'b0, done_o}, 136'd1);
    tick();
    check("idle_at_k3", {135'b0, busy_o}, 136'd0);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (phy.ser_start_o) begin
        n_ser++;
        if (frame_q.size() == 0) check("ser_start_spurious", {135'b0, phy.ser_start_o}, 136'd0);
        else check("ser_frame", {88'b0, phy.ser_frame_o}, {88'b0, frame_q.pop_front()});
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check("done_spurious", {135'b0, done_o}, 136'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("err_timeout_at_done", {135'b0, err_timeout_o}, {135'b0, e.to});
          check("err_crc_at_done", {135'b0, err_crc_o}, {135'b0, e.crc});
          check("resp_at_done", resp_o, e.resp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ser_before;
    rst_i = 1'b1; bitclk_i = 1'b0; cmd_start_i = 1'b0; cmd_index_i = '0; cmd_arg_i = '0;
    resp_type_i = '0; crc_en_i = 1'b0; abort_i = 1'b0;
    phy.ser_done_i = 1'b0; phy.des_resp_i = '0; phy.des_complete_i = 1'b0;
    resp_good = {88'b0, 2'b00, 6'd8, 32'h1AA, crc7_ref({2'b00, 6'd8, 32'h1AA}), 1'b1};
    resp_bad  = resp_good ^ {128'b0, 8'hFE};
    resp_r2   = {8'h3F, 64'hDEAD_BEEF_0123_4567, 56'h89_ABCD_EF00_1122, 8'h00};
    tick(); tick();
    rst_i = 1'b0;

    check("rst_busy", {135'b0, busy_o}, 136'd0);
    check("rst_done", {135'b0, done_o}, 136'd0);
    check("rst_err", {134'b0, err_timeout_o, err_crc_o}, 136'd0);
    check("rst_resp", resp_o, 136'd0);
    check("rst_frame", {88'b0, phy.ser_frame_o}, 136'd0);
    check("rst_des", {133'b0, phy.des_start_o, phy.des_abort_o, phy.des_r2_mode_o}, 136'd0);

    // CMD0, no response
    expect_done(1'b0, 1'b0, 136'd0);
    start_cmd(6'd0, 32'h0, RESP_NONE, 1'b0, 48'h40_0000_0000_95);
    finish_ser();
    check("cmd0_done_m1", {135'b0, done_o}, 136'd1);
    tick();
    check("cmd0_idle_m2", {135'b0, busy_o}, 136'd0);

    // CMD8 with correct R7, corrupted R7, corrupted R7 without checking
    expect_done(1'b0, 1'b0, resp_good);
    start_cmd(6'd8, 32'h1AA, RESP_48, 1'b1, 48'h48_0000_01AA_87);
    finish_ser();
    run_resp(resp_good, 1'b0);
    check("r7_fields", {97'b0, resp_o[46:8]}, {97'b0, 1'b0, 6'd8, 32'h1AA});

    expect_done(1'b0, 1'b1, resp_bad);
    start_cmd(6'd8, 32'h1AA, RESP_48, 1'b1, 48'h48_0000_01AA_87);
    finish_ser();
    run_resp(resp_bad, 1'b0);

    expect_done(1'b0, 1'b0, resp_bad);
    start_cmd(6'd8, 32'h1AA, RESP_48, 1'b0, 48'h48_0000_01AA_87);
    finish_ser();
    run_resp(resp_bad, 1'b0);

    // Timeout: 16th bitclk rising edge in RESP aborts the deserialiser
    expect_done(1'b1, 1'b0, resp_bad);
    start_cmd(6'd17, 32'h100, RESP_48, 1'b1, frame_of(6'd17, 32'h100));
    finish_ser();
    check("to_des_start", {135'b0, phy.des_start_o}, 136'd1);
    tick();
    for (int e = 1; e <= 16; e++) begin
      bitclk_i = 1'b1;
      #1;
      check($sformatf("to_abort_edge%0d", e), {135'b0, phy.des_abort_o}, {135'b0, e == 16});
      tick();
      if (e < 16) begin
        bitclk_i = 1'b0;
        tick();
      end
    end
    check("to_done_t1", {135'b0, done_o}, 136'd1);
    bitclk_i = 1'b0;
    tick();
    check("to_flag_held", {135'b0, err_timeout_o}, 136'd1);

    // R2 with a meaningless CRC byte
    expect_done(1'b0, 1'b0, resp_r2);
    start_cmd(6'd2, 32'h0, RESP_136, 1'b1, frame_of(6'd2, 32'h0));
    finish_ser();
    run_resp(resp_r2, 1'b1);

    // Abort in RESP: no done, deserialiser abort pulse, IDLE next cycle
    start_cmd(6'd17, 32'h200, RESP_48, 1'b1, frame_of(6'd17, 32'h200));
    finish_ser();
    tick();
    abort_i = 1'b1;
    #1;
    check("abort_des_pulse", {135'b0, phy.des_abort_o}, 136'd1);
    tick();
    abort_i = 1'b0;
    check("abort_idle", {135'b0, busy_o}, 136'd0);
    check("abort_flags", {134'b0, err_timeout_o, err_crc_o}, 136'd0);

    // cmd_start held while busy yields a single command
    ser_before = n_ser;
    expect_done(1'b0, 1'b0, resp_r2);
    cmd_index_i = 6'd13; cmd_arg_i = 32'h0001_0000; resp_type_i = RESP_NONE; crc_en_i = 1'b0;
    cmd_start_i = 1'b1;
    frame_q.push_back(frame_of(6'd13, 32'h0001_0000));
    tick(); tick(); tick(); tick();
    cmd_start_i = 1'b0;
    phy.ser_done_i = 1'b1;
    tick();
    phy.ser_done_i = 1'b0;
    tick();
    check("held_start_single", 136'(n_ser - ser_before), 136'd1);

    // Reset in WAIT_CMD clears everything
    start_cmd(6'd9, 32'hABCD_0000, RESP_48, 1'b1, frame_of(6'd9, 32'hABCD_0000));
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst_busy", {135'b0, busy_o}, 136'd0);
    check("midrst_frame", {88'b0, phy.ser_frame_o}, 136'd0);
    check("midrst_resp", resp_o, 136'd0);
    tick(); tick();

    check("frames_consumed", 136'(frame_q.size()), 136'd0);
    check("dones_consumed", 136'(exp_q.size()), 136'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
